// File: rtl/exec_mul_ctrl.sv
// Iterative radix-2 shift-add multiply sequencer for the execute stage.
// Multiplies operand magnitudes, then applies the sign in a single fix-up cycle.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef ALUOP_MUL
`define ALUOP_MUL 8'h0A
`endif

module exec_mul_ctrl #(
    parameter int unsigned REG_SIZE = `REG_SIZE,
    parameter logic [7:0]  MUL_OP   = `ALUOP_MUL
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          aluop,
    input  logic [REG_SIZE-1:0] src1,
    input  logic [REG_SIZE-1:0] src2,
    input  logic                kill,
    output logic                stall,
    output logic                done,
    output logic [REG_SIZE-1:0] out,
    output logic                overflow
);

    localparam int unsigned CW = $clog2(REG_SIZE);
    localparam logic [CW-1:0] CntLast = CW'(REG_SIZE - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [CW-1:0]           r_cnt;
    logic [2*REG_SIZE-1:0]   r_acc;
    logic [2*REG_SIZE-1:0]   r_mcand;
    logic [REG_SIZE-1:0]     r_mplier;
    logic                    r_neg;
    logic [REG_SIZE-1:0]     r_out;
    logic                    r_ovf;

    logic                    w_accept;
    logic [REG_SIZE-1:0]     w_mag1;
    logic [REG_SIZE-1:0]     w_mag2;
    logic [2*REG_SIZE-1:0]   w_fixed;

    assign w_accept = start & (aluop == MUL_OP) & ~kill
                      & ((r_state == StIdle) | (r_state == StDone));

    // Negating the most-negative value yields 2^(REG_SIZE-1), correct as unsigned.
    assign w_mag1  = src1[REG_SIZE-1] ? -src1 : src1;
    assign w_mag2  = src2[REG_SIZE-1] ? -src2 : src2;
    assign w_fixed = r_neg ? -r_acc : r_acc;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_nxt = StRun;
            StRun:   if (r_cnt == CntLast) w_state_nxt = StFix;
            StFix:   w_state_nxt = StDone;
            StDone:  w_state_nxt = w_accept ? StRun : StIdle;
            default: w_state_nxt = StIdle;
        endcase
        if (kill) w_state_nxt = StIdle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_out    <= '0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{REG_SIZE{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
            r_neg    <= src1[REG_SIZE-1] ^ src2[REG_SIZE-1];
        end else if (r_state == StRun) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CntOne;
        end else if ((r_state == StFix) && !kill) begin
            r_out <= w_fixed[REG_SIZE-1:0];
            r_ovf <= (w_fixed[2*REG_SIZE-1:REG_SIZE] != {REG_SIZE{w_fixed[REG_SIZE-1]}});
        end
    end

    assign stall    = w_accept | (r_state == StRun) | (r_state == StFix);
    assign done     = (r_state == StDone);
    assign out      = r_out;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_exec_mul_ctrl.sv
// Randomized and directed bench for exec_mul_ctrl against a 64-bit arithmetic model.
`timescale 1ns/1ps
module tb_exec_mul_ctrl;

    localparam logic [7:0] MulOp = 8'h0A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  aluop;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        kill;
    logic        stall;
    logic        done;
    logic [31:0] out;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_out = '0;
    logic        exp_ovf = 1'b0;

    exec_mul_ctrl #(
        .REG_SIZE(32),
        .MUL_OP  (MulOp)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .aluop   (aluop),
        .src1    (src1),
        .src2    (src2),
        .kill    (kill),
        .stall   (stall),
        .done    (done),
        .out     (out),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] o, output logic ov);
        longint p;
        p  = longint'($signed(a)) * longint'($signed(b));
        o  = p[31:0];
        ov = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    endfunction

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input string tag);
        int n_stall;
        bit seen;
        @(posedge clk); #1;
        start = 1'b1; aluop = MulOp; src1 = a; src2 = b;
        @(negedge clk);
        chk({tag, "_acc_stall"}, 64'(stall), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        n_stall = 1;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (stall) n_stall++;
        end
        ref_mul(a, b, exp_out, exp_ovf);
        chk({tag, "_done"},      64'(seen),     64'd1);
        chk({tag, "_stall_len"}, 64'(n_stall),  64'd34);
        chk({tag, "_stall_dn"},  64'(stall),    64'd0);
        chk({tag, "_out"},       64'(out),      64'(exp_out));
        chk({tag, "_ovf"},       64'(overflow), 64'(exp_ovf));
        @(negedge clk);
        chk({tag, "_pulse"},     64'(done),     64'd0);
        chk({tag, "_hold"},      64'(out),      64'(exp_out));
    endtask

    task automatic expect_no_done(input int cycles, input string tag);
        int n_done = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk({tag, "_nodone"}, 64'(n_done), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0:       v = 32'($urandom_range(0, 100));
            1:       v = -32'($urandom_range(0, 100));
            2: begin
                case ($urandom_range(0, 3))
                    0:       v = 32'h8000_0000;
                    1:       v = 32'h7FFF_FFFF;
                    2:       v = 32'hFFFF_FFFF;
                    default: v = 32'h0;
                endcase
            end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int gap;
        bit seen;
        rst_n = 1'b0; start = 1'b0; aluop = '0; src1 = '0; src2 = '0; kill = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 64'(stall),    64'd0);
        chk("rst_done",  64'(done),     64'd0);
        chk("rst_out",   64'(out),      64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_mul(32'd7,         32'd6,         "basic");
        run_mul(-32'd3,        32'd5,         "neg");
        run_mul(32'd0,         32'h8000_0000, "zero");
        run_mul(32'h0001_0000, 32'h0001_0000, "ovf_big");
        run_mul(32'h8000_0000, 32'hFFFF_FFFF, "ovf_minneg");
        run_mul(32'h8000_0000, 32'd1,         "minneg_x1");

        for (int i = 0; i < 16; i++) begin
            run_mul(pick_operand(), pick_operand(), $sformatf("rnd%0d", i));
        end

        // Kill in RUN: no result, out keeps its last value.
        run_mul(32'd11, 32'd13, "pre_kill");
        @(posedge clk); #1;
        start = 1'b1; aluop = MulOp; src1 = 32'd5; src2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(negedge clk);
        chk("kill_stall_hi", 64'(stall), 64'd1);
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_stall_lo", 64'(stall), 64'd0);
        expect_no_done(50, "kill");
        chk("kill_out", 64'(out), 64'(exp_out));
        chk("kill_ovf", 64'(overflow), 64'(exp_ovf));

        // Kill beats start in the same cycle.
        @(posedge clk); #1;
        start = 1'b1; kill = 1'b1; aluop = MulOp; src1 = 32'd7; src2 = 32'd7;
        @(negedge clk);
        chk("ks_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        @(negedge clk);
        chk("ks_stall_next", 64'(stall), 64'd0);
        expect_no_done(45, "ks");

        // Non-MUL aluop is ignored.
        @(posedge clk); #1;
        start = 1'b1; aluop = MulOp ^ 8'h01; src1 = 32'd3; src2 = 32'd3;
        @(negedge clk);
        chk("nomul_stall", 64'(stall), 64'd0);
        expect_no_done(40, "nomul");
        chk("nomul_out", 64'(out), 64'(exp_out));
        @(posedge clk); #1;
        start = 1'b0;

        // Back-to-back: start held, operands change after the first accept.
        @(posedge clk); #1;
        start = 1'b1; aluop = MulOp; src1 = 32'd3; src2 = 32'd4;
        @(posedge clk); #1;
        src1 = 32'd2; src2 = 32'd9;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("b2b_done1",  64'(seen),  64'd1);
        chk("b2b_out1",   64'(out),   64'd12);
        chk("b2b_stall1", 64'(stall), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        gap = 1;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            gap++;
        end
        chk("b2b_done2", 64'(seen), 64'd1);
        chk("b2b_gap",   64'(gap),  64'd34);
        chk("b2b_out2",  64'(out),  64'd18);
        ref_mul(32'd2, 32'd9, exp_out, exp_ovf);

        // Asynchronous reset mid-RUN with nonzero outputs held.
        run_mul(32'h8000_0000, 32'hFFFF_FFFF, "pre_rst");
        @(posedge clk); #1;
        start = 1'b1; aluop = MulOp; src1 = 32'd9; src2 = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out",   64'(out),      64'd0);
        chk("arst_ovf",   64'(overflow), 64'd0);
        chk("arst_done",  64'(done),     64'd0);
        chk("arst_stall", 64'(stall),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_no_done(40, "arst");
        run_mul(32'd2, 32'd3, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
